sd_cmd_sequencer: RTL

- Sequences the SPI SD command path: runs the card init flow (CMD0, CMD8, CMD55/ACMD41 loop, CMD58), then serves single-block read requests (CMD17).
- Drives the start/start40/cmd/arg/readit inputs of the command-prepare stage.
- Consumes decoded responses from the command manager; holds card state (ready, SDHC) for the rest of the SPISD block.

---
 rtl/sd_pkg.sv | 61 ++++++
 rtl/sd_timer.sv | 26 ++
 rtl/sd_cmd_sequencer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/sd_pkg.sv
// Shared types and constants for the SPI SD command sequencer.
// States, command indices, arguments, R1 codes and error codes.
package sd_pkg;

  typedef enum logic [4:0] {
    S_IDLE,
    S_PWRUP,
    S_I_CMD0,
    S_W_CMD0,
    S_I_CMD8,
    S_W_CMD8,
    S_I_CMD55,
    S_W_CMD55,
    S_I_ACMD41,
    S_W_ACMD41,
    S_GAP,
    S_I_CMD58,
    S_W_CMD58,
    S_READY,
    S_I_CMD17,
    S_W_CMD17,
    S_WDATA,
    S_ERROR
  } state_t;

  localparam logic [5:0] CMD_GO_IDLE  = 6'd0;
  localparam logic [5:0] CMD_SEND_IF  = 6'd8;
  localparam logic [5:0] CMD_READ     = 6'd17;
  localparam logic [5:0] CMD_APP      = 6'd55;
  localparam logic [5:0] ACMD_OP_COND = 6'd41;
  localparam logic [5:0] CMD_READ_OCR = 6'd58;

  localparam logic [31:0] ARG_CMD8 = 32'h0000_01AA;
  localparam logic [31:0] ARG_HCS  = 32'h4000_0000;

  localparam logic [7:0] R1_IDLE  = 8'h01;
  localparam logic [7:0] R1_READY = 8'h00;
  localparam int         R1_ILLEGAL = 2;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_CMD0    = 3'd1;
  localparam logic [2:0] ERR_CMD8    = 3'd2;
  localparam logic [2:0] ERR_ACMD41  = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;
  localparam logic [2:0] ERR_READ    = 3'd5;

  function automatic logic is_issue(state_t s);
    return s inside {S_I_CMD0, S_I_CMD8, S_I_CMD55,
                     S_I_ACMD41, S_I_CMD58, S_I_CMD17};
  endfunction

  function automatic logic is_r3(state_t s);
    return s inside {S_I_CMD8, S_I_CMD58};
  endfunction

  function automatic logic is_wait(state_t s);
    return s inside {S_W_CMD0, S_W_CMD8, S_W_CMD55,
                     S_W_ACMD41, S_W_CMD58, S_W_CMD17};
  endfunction

endpackage

// File: rtl/sd_timer.sv
// Loadable down-counter with zero flag; shared by power-up,
// response timeout and ACMD41 retry-gap timing.
module sd_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sd_cmd_sequencer.sv
// SPI SD command sequencer: card init (CMD0/8/55/41/58) then
// single-block reads (CMD17) via the command-prepare stage.
module sd_cmd_sequencer
  import sd_pkg::*;
#(
  parameter logic [15:0] POWERUP_CYC  = 16'd50000,
  parameter logic [23:0] RESP_TIMEOUT = 24'd1000000,
  parameter logic [15:0] MAX_RETRY    = 16'd2000,
  parameter logic [15:0] RETRY_GAP    = 16'd10000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_req,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  input  logic        resp_valid,
  input  logic [7:0]  resp_r1,
  input  logic [31:0] resp_ext,
  input  logic        data_done,
  output logic        start,
  output logic        start40,
  output logic [5:0]  cmd,
  output logic [31:0] arg,
  output logic        readit,
  output logic        busy,
  output logic        init_done,
  output logic        sdhc,
  output logic        rd_ack,
  output logic        error,
  output logic [2:0]  err_code
);

  // Timer loads: a WAIT state spans RESP_TIMEOUT-1 clks after issue.
  localparam logic [23:0] PWR_LD = {8'd0, POWERUP_CYC} - 24'd1;
  localparam logic [23:0] TO_LD  = RESP_TIMEOUT - 24'd2;
  localparam logic [23:0] GAP_LD = {8'd0, RETRY_GAP} - 24'd1;

  state_t      state, state_n;
  logic [15:0] retry, retry_n;
  logic        v2, v2_n;
  logic        sdhc_n;
  logic [2:0]  err_n;
  logic [5:0]  cmd_n;
  logic [31:0] arg_n;
  logic        readit_n;
  logic        tload, tzero;
  logic [23:0] tval;
  logic        last_try;
  logic        r1_ok;
  logic        unused_ext;

  assign last_try   = (retry + 16'd1) >= MAX_RETRY;
  assign r1_ok      = (resp_r1 == R1_READY);
  assign unused_ext = ^{resp_ext[31], resp_ext[29:12]};

  sd_timer #(.W(24)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tload),
    .load_val (tval),
    .zero     (tzero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      retry    <= '0;
      v2       <= 1'b0;
      sdhc     <= 1'b0;
      err_code <= ERR_NONE;
      cmd      <= '0;
      arg      <= '0;
      readit   <= 1'b0;
    end else begin
      state    <= state_n;
      retry    <= retry_n;
      v2       <= v2_n;
      sdhc     <= sdhc_n;
      err_code <= err_n;
      cmd      <= cmd_n;
      arg      <= arg_n;
      readit   <= readit_n;
    end
  end

  always_comb begin
    state_n  = state;
    retry_n  = retry;
    v2_n     = v2;
    sdhc_n   = sdhc;
    err_n    = err_code;
    cmd_n    = cmd;
    arg_n    = arg;
    readit_n = readit;
    tload    = is_issue(state);
    tval     = TO_LD;
    unique case (state)
      S_PWRUP: if (tzero) state_n = S_I_CMD0;
      S_I_CMD0:   state_n = S_W_CMD0;
      S_I_CMD8:   state_n = S_W_CMD8;
      S_I_CMD55:  state_n = S_W_CMD55;
      S_I_ACMD41: state_n = S_W_ACMD41;
      S_I_CMD58:  state_n = S_W_CMD58;
      S_I_CMD17:  state_n = S_W_CMD17;
      S_W_CMD0: if (resp_valid) begin
        if (resp_r1 == R1_IDLE) begin
          state_n = S_I_CMD8;
          retry_n = '0;
        end else if (last_try) begin
          state_n = S_ERROR;
          err_n   = ERR_CMD0;
        end else begin
          state_n = S_I_CMD0;
          retry_n = retry + 16'd1;
        end
      end
      S_W_CMD8: if (resp_valid) begin
        if (resp_r1 == R1_IDLE &&
            resp_ext[11:0] == ARG_CMD8[11:0]) begin
          state_n = S_I_CMD55;
          v2_n    = 1'b1;
        end else if (resp_r1[R1_ILLEGAL]) begin
          state_n = S_I_CMD55;
          v2_n    = 1'b0;
        end else begin
          state_n = S_ERROR;
          err_n   = ERR_CMD8;
        end
      end
      S_W_CMD55: if (resp_valid) begin
        if (r1_ok || resp_r1 == R1_IDLE) begin
          state_n = S_I_ACMD41;
        end else begin
          state_n = S_ERROR;
          err_n   = ERR_ACMD41;
        end
      end
      S_W_ACMD41: if (resp_valid) begin
        if (r1_ok) begin
          state_n = v2 ? S_I_CMD58 : S_READY;
        end else if (resp_r1 == R1_IDLE && !last_try) begin
          state_n = S_GAP;
          retry_n = retry + 16'd1;
          tload   = 1'b1;
          tval    = GAP_LD;
        end else begin
          state_n = S_ERROR;
          err_n   = ERR_ACMD41;
        end
      end
      S_GAP: if (tzero) state_n = S_I_CMD55;
      S_W_CMD58: if (resp_valid) begin
        if (r1_ok) begin
          state_n = S_READY;
          sdhc_n  = resp_ext[30];
        end else begin
          state_n = S_ERROR;
          err_n   = ERR_ACMD41;
        end
      end
      S_READY: if (rd_req) state_n = S_I_CMD17;
      S_W_CMD17: if (resp_valid) begin
        if (r1_ok) begin
          state_n = S_WDATA;
          tload   = 1'b1;
        end else begin
          state_n = S_ERROR;
          err_n   = ERR_READ;
        end
      end
      S_WDATA: begin
        if (data_done) begin
          state_n = S_READY;
        end else if (tzero) begin
          state_n = S_ERROR;
          err_n   = ERR_TIMEOUT;
        end
      end
      default: ;
    endcase
    if (is_wait(state) && !resp_valid && tzero) begin
      state_n = S_ERROR;
      err_n   = ERR_TIMEOUT;
    end
    if (init_req) begin
      state_n = S_PWRUP;
      retry_n = '0;
      v2_n    = 1'b0;
      sdhc_n  = 1'b0;
      err_n   = ERR_NONE;
      tload   = 1'b1;
      tval    = PWR_LD;
    end
    // Command fields are latched on entry to the issue state.
    unique case (1'b1)
      state_n == S_I_CMD0: begin
        cmd_n = CMD_GO_IDLE; arg_n = '0; readit_n = 1'b0;
      end
      state_n == S_I_CMD8: begin
        cmd_n = CMD_SEND_IF; arg_n = ARG_CMD8; readit_n = 1'b0;
      end
      state_n == S_I_CMD55: begin
        cmd_n = CMD_APP; arg_n = '0; readit_n = 1'b0;
      end
      state_n == S_I_ACMD41: begin
        cmd_n    = ACMD_OP_COND;
        arg_n    = v2 ? ARG_HCS : '0;
        readit_n = 1'b0;
      end
      state_n == S_I_CMD58: begin
        cmd_n = CMD_READ_OCR; arg_n = '0; readit_n = 1'b0;
      end
      state_n == S_I_CMD17: begin
        cmd_n    = CMD_READ;
        arg_n    = sdhc ? rd_addr : {rd_addr[22:0], 9'd0};
        readit_n = 1'b1;
      end
      default: ;
    endcase
  end

  assign start     = is_issue(state) && !is_r3(state) && !init_req;
  assign start40   = is_r3(state) && !init_req;
  assign rd_ack    = (state == S_WDATA) && data_done && !init_req;
  assign busy      = !(state inside {S_IDLE, S_READY, S_ERROR});
  assign init_done = (state == S_READY);
  assign error     = (state == S_ERROR);

endmodule
